// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache: same-cycle hits, BUSYWAIT stall while a
// 16-byte line is fetched from block-wide instruction memory on a miss.
module icache_direct_mapped #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           PC,
  output logic [31:0]           INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [ADDR_WIDTH-5:0] MEM_ADDRESS,
  input  logic [127:0]          MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  localparam int unsigned TAG_BITS = ADDR_WIDTH - INDEX_BITS - 4;
  localparam int unsigned Lines    = 1 << INDEX_BITS;

  typedef enum logic [0:0] {StIdle, StMemReq} state_e;

  state_e state_q, state_d;

  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;

  logic [Lines-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [Lines];
  logic [127:0]        data_q [Lines];

  logic                  first_q;
  logic [ADDR_WIDTH-5:0] miss_addr_q;
  logic [31:0]           instr_q;

  logic                  hit;
  logic                  fill;
  logic [127:0]          line;
  logic [31:0]           word;
  logic [INDEX_BITS-1:0] miss_idx;
  logic [TAG_BITS-1:0]   miss_tag;
  logic                  unused_pc;

  assign offset    = PC[3:2];
  assign index     = PC[INDEX_BITS+3:4];
  assign tag       = PC[ADDR_WIDTH-1:INDEX_BITS+4];
  assign unused_pc = ^{PC[31:ADDR_WIDTH], PC[1:0]};

  assign line     = data_q[index];
  assign word     = line[{offset, 5'b0} +: 32];
  assign hit      = valid_q[index] && (tag_q[index] == tag);
  assign miss_idx = miss_addr_q[INDEX_BITS-1:0];
  assign miss_tag = miss_addr_q[ADDR_WIDTH-5:INDEX_BITS];

  // The first MEM_REQ edge is never a fill, giving memory a cycle to see MEM_READ.
  assign fill = (state_q == StMemReq) && !first_q && !MEM_BUSYWAIT;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!hit) state_d = StMemReq;
      StMemReq: if (fill) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q     <= '0;
      first_q     <= 1'b0;
      miss_addr_q <= '0;
      instr_q     <= '0;
    end else begin
      if (state_q == StIdle) begin
        if (hit) begin
          instr_q <= word;
        end else begin
          miss_addr_q <= {tag, index};
          first_q     <= 1'b1;
        end
      end
      if (state_q == StMemReq) first_q <= 1'b0;
      if (fill) valid_q[miss_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are deliberately left uncleared by reset.
  always_ff @(posedge CLK) begin
    if (!RESET && fill) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= MEM_READDATA;
    end
  end

  always_comb begin
    INSTRUCTION = '0;
    BUSYWAIT    = 1'b0;
    MEM_READ    = 1'b0;
    MEM_ADDRESS = '0;
    if (!RESET) begin
      unique case (state_q)
        StIdle: begin
          BUSYWAIT    = !hit;
          INSTRUCTION = hit ? word : instr_q;
        end
        StMemReq: begin
          BUSYWAIT    = 1'b1;
          MEM_READ    = 1'b1;
          MEM_ADDRESS = miss_addr_q;
          INSTRUCTION = instr_q;
        end
        default: ;
      endcase
    end
  end

endmodule
